fsm_seq_arbiter: RTL and testbench

FSM_SEQ_ARBITER -- requirements
Module: fsm_seq_arbiter

---
 rtl/fsm_seq_arbiter.sv | 138 +++++++++++++
 tb/tb_fsm_seq_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_arbiter.sv
// fsm_seq_arbiter: round-robin arbiter that streams one requester's frame at a time
// through a shared external Mealy detector and counts the detector's hits per frame.
// Build option: define FSM_SEQ_ARB_LSB_FIRST_EN to shift frames LSB first (default MSB first).
module fsm_seq_arbiter #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             req,
    input  logic [4*FRAME_W-1:0]   frame_in,
    output logic [3:0]             gnt,
    output logic                   det_rst,
    output logic                   det_x,
    input  logic                   det_y,
    output logic                   done,
    output logic [1:0]             done_id,
    output logic [CNT_W-1:0]       hit_cnt
);

    localparam int BW = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_ptr;
    logic [1:0]         r_idx;
    logic [1:0]         r_done_id;
    logic [3:0]         r_gnt;
    logic [FRAME_W-1:0] r_sr;
    logic [FRAME_W-1:0] w_sr_next;
    logic [BW-1:0]      r_bit;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hit;
    logic [1:0]         w_win;
    logic               w_any;
    logic               w_last;
    logic               w_bit_out;

`ifdef FSM_SEQ_ARB_LSB_FIRST_EN
    assign w_bit_out = r_sr[0];
    assign w_sr_next = r_sr >> 1;
`else
    assign w_bit_out = r_sr[FRAME_W-1];
    assign w_sr_next = r_sr << 1;
`endif

    assign w_last  = (r_bit == BW'(FRAME_W - 1));
    assign gnt     = r_gnt;
    assign done_id = r_done_id;
    assign hit_cnt = r_hit;

    // Round-robin winner: first set req bit at or after r_ptr (descending loop so nearest wins)
    always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
                w_any = 1'b1;
            end
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next  = r_state;
        det_rst = 1'b0;
        det_x   = 1'b0;
        done    = 1'b0;
        case (r_state)
            IDLE:    w_next = w_any ? CLR : IDLE;
            CLR: begin
                det_rst = 1'b1;
                w_next  = SHIFT;
            end
            SHIFT: begin
                det_x  = w_bit_out;
                w_next = w_last ? DONE : SHIFT;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Grant, frame shifter, hit counting and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= 2'd0;
            r_idx     <= 2'd0;
            r_gnt     <= 4'd0;
            r_sr      <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_hit     <= '0;
            r_done_id <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= 4'b0001 << w_win;
                        r_idx <= w_win;
                        r_sr  <= frame_in[w_win*FRAME_W +: FRAME_W];
                        r_cnt <= '0;
                        r_bit <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_bit <= r_bit + 1'b1;
                    r_cnt <= r_cnt + CNT_W'(det_y);
                    if (w_last) begin
                        r_hit     <= r_cnt + CNT_W'(det_y);
                        r_done_id <= r_idx;
                    end
                end
                DONE: begin
                    r_gnt <= 4'd0;
                    r_ptr <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// tb_fsm_seq_arbiter: directed checks of arbitration order, frame timing, bit order and reset.
module tb_fsm_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] frame_in = 32'd0;
    logic [3:0]  gnt;
    logic        det_rst;
    logic        det_x;
    logic        det_y;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_cnt;
    int          checks = 0;
    int          errors = 0;

    fsm_seq_arbiter #(.FRAME_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .frame_in(frame_in), .gnt(gnt),
        .det_rst(det_rst), .det_x(det_x), .det_y(det_y), .done(done),
        .done_id(done_id), .hit_cnt(hit_cnt)
    );

    // Echo detector: hit count equals popcount of the frame
    assign det_y = det_x;

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] f, input int i);
`ifdef FSM_SEQ_ARB_LSB_FIRST_EN
        return f[i];
`else
        return f[7-i];
`endif
    endfunction

    // Called at a negedge in IDLE with req set up; returns at the negedge of the IDLE cycle after DONE.
    // At SHIFT cycle index chg_at (-1 = during CLR) req and frame_in are replaced by new values.
    task automatic do_frame(input logic [1:0] id, input logic [7:0] f, input logic [3:0] hits,
                            input int chg_at, input logic [3:0] req_new, input logic [31:0] fr_new);
        logic [3:0] g;
        g = 4'b0001 << id;
        tick;
        chk("clr_gnt", gnt, g);
        chk("clr_det_rst", det_rst, 1);
        chk("clr_det_x", det_x, 0);
        chk("clr_done", done, 0);
        if (chg_at < 0) begin
            req = req_new;
            frame_in = fr_new;
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("shift%0d_det_x", i), det_x, exp_bit(f, i));
            chk("shift_det_rst", det_rst, 0);
            chk("shift_gnt", gnt, g);
            chk("shift_done", done, 0);
            if (i == chg_at) begin
                req = req_new;
                frame_in = fr_new;
            end
        end
        tick;
        chk("done", done, 1);
        chk("done_id", done_id, id);
        chk("done_hit_cnt", hit_cnt, hits);
        chk("done_gnt", gnt, g);
        chk("done_det_x", det_x, 0);
        tick;
        chk("idle_done", done, 0);
        chk("idle_gnt", gnt, 0);
        chk("hold_done_id", done_id, id);
        chk("hold_hit_cnt", hit_cnt, hits);
    endtask

    initial begin
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_det_rst", det_rst, 0);
        chk("rst_det_x", det_x, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("idle_noreq_gnt", gnt, 0);
        chk("idle_noreq_det_rst", det_rst, 0);

        // All requesting: round robin 0,1,2,3,0
        req = 4'b1111;
        frame_in = {8'h81, 8'h0F, 8'h00, 8'hFF};
        do_frame(2'd0, 8'hFF, 4'd8, 8, 4'b1111, frame_in);
        do_frame(2'd1, 8'h00, 4'd0, 8, 4'b1111, frame_in);
        do_frame(2'd2, 8'h0F, 4'd4, 8, 4'b1111, frame_in);
        do_frame(2'd3, 8'h81, 4'd2, 8, 4'b1111, frame_in);
        do_frame(2'd0, 8'hFF, 4'd8, -1, 4'b0000, frame_in);
        tick;
        chk("idle_stay_gnt", gnt, 0);
        chk("idle_stay_det_rst", det_rst, 0);

        // Single request, frame A5
        req = 4'b0001;
        frame_in = {24'h0, 8'hA5};
        do_frame(2'd0, 8'hA5, 4'd4, -1, 4'b0000, 32'h0);

        // Bit order with frame 01
        req = 4'b0001;
        frame_in = {24'h0, 8'h01};
        do_frame(2'd0, 8'h01, 4'd1, -1, 4'b0000, 32'h0);

        // Mid-frame req drop and frame_in change at 3rd SHIFT cycle
        req = 4'b0100;
        frame_in = {8'h00, 8'hF0, 16'h0};
        do_frame(2'd2, 8'hF0, 4'd4, 2, 4'b0000, 32'h0);

        // Pointer now 3: requester 3 beats requester 0
        req = 4'b1001;
        frame_in = {8'h3C, 16'h0, 8'hFF};
        do_frame(2'd3, 8'h3C, 4'd4, -1, 4'b0000, 32'h0);

        // Reset in the 5th SHIFT cycle
        req = 4'b0001;
        frame_in = {24'h0, 8'hFF};
        tick;
        chk("pre_rst_det_rst", det_rst, 1);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) tick;
        chk("pre_rst_gnt", gnt, 4'b0001);
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_det_x", det_x, 0);
        chk("arst_det_rst", det_rst, 0);
        chk("arst_done", done, 0);
        chk("arst_done_id", done_id, 0);
        chk("arst_hit_cnt", hit_cnt, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("post_rst_no_done", done, 0);
        end

        // After reset requester 0 has priority, so 1010 grants requester 1 first
        req = 4'b1010;
        frame_in = {8'hFF, 8'h00, 8'h07, 8'h00};
        do_frame(2'd1, 8'h07, 4'd3, -1, 4'b0000, frame_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
